// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the tx AXIS frame arbiter.
package tx_arb_pkg;

  localparam int MAX_PORTS = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: rotate the request vector so the port
// after `last` sits at bit 0, then priority-encode the lowest set bit.
module rr_select
  import tx_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = grant_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  int             start;
  int             offset;

  always_comb begin
    req2    = {req, req};
    start   = int'(last) + 1;
    rot     = N'(req2 >> start);
    offset  = 0;
    gnt_any = 1'b0;
    // Descending scan so the lowest rotated position is the one that sticks.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        offset  = j;
        gnt_any = 1'b1;
      end
    end
    gnt_idx = GW'((start + offset) % N);
  end

endmodule

// File: rtl/tx_axis_arbiter.sv
// Frame-granular round-robin arbiter feeding the tx MAC AXIS input.
// TX_ARB_STRICT_PRIO_EN: fixed priority (lowest index wins) instead of round robin.
module tx_axis_arbiter
  import tx_arb_pkg::*;
#(
  parameter  int DATA_WIDTH  = 64,
  parameter  int N_PORTS     = 4,
  localparam int DATA_NBYTES = DATA_WIDTH / 8,
  localparam int GW          = grant_width(N_PORTS)
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic [N_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [N_PORTS*DATA_NBYTES-1:0] s_axis_tkeep,
  input  logic [N_PORTS-1:0]             s_axis_tvalid,
  input  logic [N_PORTS-1:0]             s_axis_tlast,
  output logic [N_PORTS-1:0]             s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m00_axis_tdata,
  output logic [DATA_NBYTES-1:0]         m00_axis_tkeep,
  output logic                           m00_axis_tvalid,
  output logic                           m00_axis_tlast,
  input  logic                           m00_axis_tready,
  output logic [GW-1:0]                  o_grant,
  output logic                           o_busy
);

  // Handshake rule on every AXIS link here: a beat moves in a cycle where
  // tvalid and tready are both high at the rising edge; nothing else counts.

  arb_state_t    state;
  logic [GW-1:0] grant;
  logic [GW-1:0] sel_last;
  logic [GW-1:0] sel_idx;
  logic          sel_any;
  logic          frame_done;

`ifdef TX_ARB_STRICT_PRIO_EN
  // Pinning the pointer at N-1 turns the rotating search into fixed priority.
  assign sel_last = GW'(N_PORTS - 1);
`else
  logic [GW-1:0] last;
  assign sel_last = last;
`endif

  rr_select #(
    .N  (N_PORTS),
    .GW (GW)
  ) u_rr_select (
    .req     (s_axis_tvalid),
    .last    (sel_last),
    .gnt_idx (sel_idx),
    .gnt_any (sel_any)
  );

  assign frame_done = (state == ARB_XFER) && s_axis_tvalid[grant] &&
                      m00_axis_tready && s_axis_tlast[grant];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ARB_IDLE;
      grant <= '0;
`ifndef TX_ARB_STRICT_PRIO_EN
      last  <= GW'(N_PORTS - 1);
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (sel_any) begin
            grant <= sel_idx;
            state <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (frame_done) begin
`ifndef TX_ARB_STRICT_PRIO_EN
            last  <= grant;
`endif
            state <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  // Data path is a pure mux while a frame is locked; zeros otherwise.
  always_comb begin
    m00_axis_tdata  = '0;
    m00_axis_tkeep  = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    s_axis_tready   = '0;
    if (state == ARB_XFER) begin
      m00_axis_tdata       = s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      m00_axis_tkeep       = s_axis_tkeep[int'(grant)*DATA_NBYTES +: DATA_NBYTES];
      m00_axis_tvalid      = s_axis_tvalid[grant];
      m00_axis_tlast       = s_axis_tlast[grant];
      s_axis_tready[grant] = m00_axis_tready;
    end
  end

  assign o_grant = grant;
  assign o_busy  = (state == ARB_XFER);

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Bench for tx_axis_arbiter: random per-port frame sources checked against a
// frame-level arbitration model and an expected-beat queue.
module tb_tx_axis_arbiter;

  localparam int DW = 64;
  localparam int NB = DW / 8;
  localparam int NP = 4;
  localparam int GW = 2;
  localparam int W  = DW + NB + 1;
  localparam int MAXLEN = 8;

  // ---------------- clock / reset ----------------
  logic i_clk;
  logic i_reset_n;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- DUT ----------------
  logic [NP*DW-1:0] s_tdata;
  logic [NP*NB-1:0] s_tkeep;
  logic [NP-1:0]    s_tvalid;
  logic [NP-1:0]    s_tlast;
  logic [NP-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [NB-1:0]    m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic [GW-1:0]    o_grant;
  logic             o_busy;

  tx_axis_arbiter #(
    .DATA_WIDTH (DW),
    .N_PORTS    (NP)
  ) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .s_axis_tdata    (s_tdata),
    .s_axis_tkeep    (s_tkeep),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_tready   (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tkeep  (m_tkeep),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .o_grant         (o_grant),
    .o_busy          (o_busy)
  );

  // ---------------- bench state ----------------
  int n_tests;
  int n_fail;

  // frame sources
  logic [DW-1:0] frm_data [NP][MAXLEN];
  logic [NB-1:0] frm_keep [NP][MAXLEN];
  int            cur_len  [NP];
  int            cur_beat [NP];
  bit            has_frame[NP];
  int            frame_cnt[NP];

  // stimulus knobs
  logic [NP-1:0] en_mask;
  int            p_new;
  int            p_gap;
  int            p_ready;
  int            len_min;
  int            len_max;
  bit            ready_q[$];

  // reference model / scoreboard
  bit             mdl_busy;
  int             mdl_g;
  int             mdl_last;
  logic [W-1:0]   exp_q[$];
  int             gnt_log[$];
  bit             prev_busy;
  int             out_beats;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: search from the port after the last winner, wrapping.
  function automatic int pick(input logic [NP-1:0] req, input int last);
    int start;
`ifdef TX_ARB_STRICT_PRIO_EN
    start = 0;
`else
    start = (last + 1) % NP;
`endif
    for (int k = 0; k < NP; k++) begin
      if (req[(start + k) % NP]) return (start + k) % NP;
    end
    return -1;
  endfunction

  function automatic bit any_frame();
    for (int p = 0; p < NP; p++) if (has_frame[p]) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- drivers ----------------
  task automatic new_frame(input int p, input int len);
    for (int b = 0; b < len; b++) begin
      frm_data[p][b] = {8'(p), 8'(frame_cnt[p]), 8'(b), 8'h00, 32'($urandom())};
      frm_keep[p][b] = (b == len - 1) ? (8'hff >> $urandom_range(0, 7)) : 8'hff;
    end
    cur_len[p]   = len;
    cur_beat[p]  = 0;
    has_frame[p] = 1'b1;
    frame_cnt[p]++;
  endtask

  task automatic drive_all();
    int b;
    for (int p = 0; p < NP; p++) begin
      if (has_frame[p]) begin
        b = cur_beat[p];
        s_tvalid[p]           = !(int'($urandom_range(0, 99)) < p_gap);
        s_tdata[p*DW +: DW]   = frm_data[p][b];
        s_tkeep[p*NB +: NB]   = frm_keep[p][b];
        s_tlast[p]            = (b == cur_len[p] - 1);
      end else begin
        s_tvalid[p]           = 1'b0;
        s_tlast[p]            = 1'b0;
        s_tdata[p*DW +: DW]   = {32'($urandom()), 32'($urandom())};
        s_tkeep[p*NB +: NB]   = '0;
      end
    end
    if (ready_q.size() != 0) m_tready = ready_q.pop_front();
    else                     m_tready = (int'($urandom_range(0, 99)) < p_ready);
  endtask

  // One clock: check outputs at the falling edge, then update sources after the rise.
  task automatic cycle();
    logic [NP-1:0] v, l, r;
    logic          mr;
    logic [W-1:0]  obs_beat;
    logic [W-1:0]  e;
    int            g;
    @(negedge i_clk);
    v  = s_tvalid;
    l  = s_tlast;
    r  = s_tready;
    mr = m_tready;
    obs_beat = {m_tdata, m_tkeep, m_tlast};
    if (!mdl_busy) begin
      check_eq("idle_busy",   W'(o_busy),   W'(0));
      check_eq("idle_tvalid", W'(m_tvalid), W'(0));
      check_eq("idle_tready", W'(r),        W'(0));
      check_eq("idle_zero",   obs_beat,     W'(0));
      g = pick(v, mdl_last);
      if (g >= 0) begin
        mdl_busy = 1'b1;
        mdl_g    = g;
        for (int b = cur_beat[g]; b < cur_len[g]; b++)
          exp_q.push_back({frm_data[g][b], frm_keep[g][b], (b == cur_len[g] - 1)});
      end
    end else begin
      check_eq("xfer_busy",   W'(o_busy),   W'(1));
      check_eq("xfer_grant",  W'(o_grant),  W'(mdl_g));
      check_eq("xfer_tready", W'(r),        W'(mr) << mdl_g);
      check_eq("xfer_tvalid", W'(m_tvalid), W'(v[mdl_g]));
      if (v[mdl_g] && mr) begin
        out_beats++;
        check_eq("beat_expected", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("beat_data", obs_beat, e);
        end
        if (l[mdl_g]) begin
          mdl_last = mdl_g;
          mdl_busy = 1'b0;
        end
      end
    end
    if (o_busy && !prev_busy) gnt_log.push_back(int'(o_grant));
    prev_busy = o_busy;
    @(posedge i_clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (v[p] && r[p]) begin
        cur_beat[p]++;
        if (cur_beat[p] >= cur_len[p]) has_frame[p] = 1'b0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (!has_frame[p] && en_mask[p] && int'($urandom_range(0, 99)) < p_new)
        new_frame(p, int'($urandom_range(len_min, len_max)));
    end
    drive_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    en_mask = '0;
    while ((mdl_busy || exp_q.size() != 0 || any_frame()) && n < budget) begin
      cycle();
      n++;
    end
    check_eq("drain_done", W'(mdl_busy || exp_q.size() != 0 || any_frame()), W'(0));
  endtask

  task automatic reset_model();
    mdl_busy  = 1'b0;
    mdl_g     = 0;
    mdl_last  = NP - 1;
    prev_busy = 1'b0;
    exp_q.delete();
    for (int p = 0; p < NP; p++) has_frame[p] = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int start_beats;
    int budget;
    int exp_g;
    n_tests   = 0;
    n_fail    = 0;
    out_beats = 0;
    en_mask   = '0;
    p_new     = 0;
    p_gap     = 0;
    p_ready   = 100;
    len_min   = 1;
    len_max   = 4;
    for (int p = 0; p < NP; p++) frame_cnt[p] = 0;
    reset_model();
    i_reset_n = 1'b0;
    drive_all();

    // 1: reset state, then release with port 2 already requesting
    new_frame(2, 3);
    drive_all();
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_busy",   W'(o_busy),   W'(0));
    check_eq("rst_grant",  W'(o_grant),  W'(0));
    check_eq("rst_tvalid", W'(m_tvalid), W'(0));
    check_eq("rst_tready", W'(s_tready), W'(0));
    i_reset_n = 1'b1;
    gnt_log.delete();
    drain(50);
    check_eq("t1_ngrants", W'(gnt_log.size()), W'(1));
    if (gnt_log.size() != 0) check_eq("t1_grant", W'(gnt_log[0]), W'(2));

    // 2: all ports stream 3-beat frames back to back
    en_mask = '1; p_new = 100; p_gap = 0; p_ready = 100; len_min = 3; len_max = 3;
    gnt_log.delete();
    run(40);
    check_eq("t2_ngrants", W'(gnt_log.size()), W'(10));
    for (int i = 1; i < gnt_log.size(); i++) begin
`ifdef TX_ARB_STRICT_PRIO_EN
      exp_g = 0;
`else
      exp_g = (gnt_log[i-1] + 1) % NP;
`endif
      check_eq("t2_order", W'(gnt_log[i]), W'(exp_g));
    end
    drain(100);

    // 3: random traffic, MAC backpressure (first pattern 1,0,0,1) and source gaps
    en_mask = '1; p_new = 30; p_gap = 20; p_ready = 60; len_min = 1; len_max = 6;
    ready_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    run(600);
    p_gap = 0; p_ready = 100;
    drain(500);

    // 4: after port 0 wins, ports 0 and 3 request in the same cycle
    new_frame(0, 2);
    drive_all();
    drain(50);
    new_frame(0, 2);
    new_frame(3, 2);
    drive_all();
    gnt_log.delete();
    drain(50);
    check_eq("t4_ngrants", W'(gnt_log.size()), W'(2));
    if (gnt_log.size() == 2) begin
`ifdef TX_ARB_STRICT_PRIO_EN
      check_eq("t4_first",  W'(gnt_log[0]), W'(0));
      check_eq("t4_second", W'(gnt_log[1]), W'(3));
`else
      check_eq("t4_first",  W'(gnt_log[0]), W'(3));
      check_eq("t4_second", W'(gnt_log[1]), W'(0));
`endif
    end

    // 5: asynchronous reset on beat 2 of a 5-beat frame from port 1
    new_frame(1, 5);
    drive_all();
    start_beats = out_beats;
    budget = 0;
    while (out_beats - start_beats < 1 && budget < 20) begin
      cycle();
      budget++;
    end
    check_eq("t5_beat1_done", W'(out_beats - start_beats), W'(1));
    #2;
    i_reset_n = 1'b0;
    #1;
    check_eq("t5_tvalid", W'(m_tvalid), W'(0));
    check_eq("t5_tready", W'(s_tready), W'(0));
    check_eq("t5_busy",   W'(o_busy),   W'(0));
    reset_model();
    drive_all();
    repeat (2) @(posedge i_clk);
    #1;
    new_frame(0, 3);
    new_frame(2, 3);
    drive_all();
    i_reset_n = 1'b1;
    gnt_log.delete();
    drain(50);
    check_eq("t5_ngrants", W'(gnt_log.size()), W'(2));
    if (gnt_log.size() == 2) begin
      check_eq("t5_first",  W'(gnt_log[0]), W'(0));
      check_eq("t5_second", W'(gnt_log[1]), W'(2));
    end

    // more random traffic after the reset
    en_mask = '1; p_new = 50; p_gap = 10; p_ready = 75; len_min = 1; len_max = 8;
    run(400);
    p_gap = 0; p_ready = 100;
    drain(500);
    check_eq("final_exp_q", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
